// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the fixed results of the divide short paths.
package mdu_pkg;

  localparam int MDU_XLEN   = 32;
  localparam int MDU_ADDR_W = 5;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  localparam logic [MDU_XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [MDU_XLEN-1:0] SIGNED_MIN    = {1'b1, {(MDU_XLEN-1){1'b0}}};

endpackage

// File: rtl/mul_div_unit_if.sv
// Request / write-back bundle between the execute stage and mul_div_unit.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int XLEN   = MDU_XLEN,
  parameter int ADDR_W = MDU_ADDR_W
);
  logic              start;
  mdu_op_e           op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [ADDR_W-1:0] rd_in;
  logic              busy;
  logic              done;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  modport master (
    output start, op, a, b, rd_in,
    input  busy, done, wb_we, wb_addr, wb_data
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output busy, done, wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/mdu_divider.sv
// Restoring divider datapath on unsigned magnitudes: load latches the
// operands, each step retires one quotient bit (XLEN steps per divide).
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // A set top bit of diff means the trial subtraction underflowed: restore.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, div_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      div_q <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Define MDU_FAST_MUL_EN to compute
// MUL* products in the accept cycle (IDLE -> FIX -> DONE) instead of shift-add.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN   = MDU_XLEN,
  parameter int ADDR_W = MDU_ADDR_W
) (
  input  logic clk,
  input  logic reset,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  Q_ONES   = XLEN'(DIV_BY_ZERO_Q);
  localparam logic [XLEN-1:0]  S_MIN    = XLEN'(SIGNED_MIN);

  mdu_state_e          state;
  mdu_op_e             op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     mcand;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q;
  logic                neg_r;
  logic                busy_q;
  logic                done_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     data_q;

  logic                a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                is_div, div_zero, div_ovf, short_path;
  logic [XLEN-1:0]     short_data;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     div_quo, div_rem, q_fix, r_fix, fix_result;
  logic                div_load, div_step;

  // Request decode: operand magnitudes, result signs and divide short paths.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    a_signed   = 1'b0;
    b_signed   = 1'b0;
    short_data = '0;
    case (bus.op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MDU_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa         = a_signed & bus.a[XLEN-1];
    sb         = b_signed & bus.b[XLEN-1];
    mag_a      = sa ? -bus.a : bus.a;
    mag_b      = sb ? -bus.b : bus.b;
    is_div     = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU) ||
                 (bus.op == MDU_REM) || (bus.op == MDU_REMU);
    div_zero   = (bus.b == '0);
    div_ovf    = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                 (bus.a == S_MIN) && (bus.b == Q_ONES);
    short_path = is_div && (div_zero || div_ovf);
    if (div_zero)
      short_data = ((bus.op == MDU_DIV) || (bus.op == MDU_DIVU)) ? Q_ONES : bus.a;
    else if (div_ovf)
      short_data = (bus.op == MDU_DIV) ? S_MIN : '0;
  end

  // Shift-add step: high half accumulates, low half shifts the multiplier out.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_fix   = neg_q ? -acc : acc;
    q_fix      = neg_q ? -div_quo : div_quo;
    r_fix      = neg_r ? -div_rem : div_rem;
    fix_result = '0;
    case (op_q)
      MDU_MUL:                         fix_result = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_result = q_fix;
      default:                         fix_result = r_fix;
    endcase
  end

  assign div_load = (state == ST_IDLE) && bus.start && is_div && !short_path;
  assign div_step = (state == ST_DIV);

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= MDU_MUL;
      rd_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_in;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (short_path) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              we_q   <= (bus.rd_in != '0);
              addr_q <= bus.rd_in;
              data_q <= short_data;
            end else if (is_div) begin
              state <= ST_DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              acc   <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
              state <= ST_FIX;
`else
              acc   <= {{XLEN{1'b0}}, mag_b};
              mcand <= mag_a;
              state <= ST_MUL;
`endif
            end
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
          we_q   <= (rd_q != '0);
          addr_q <= rd_q;
          data_q <= fix_result;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          we_q   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wb_we   = we_q;
  assign bus.wb_addr = addr_q;
  assign bus.wb_data = data_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: result, write-back and latency per
// op, plus hand sequences for start-during-busy, back-to-back and mid-op reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT   = 34;
  localparam int SHORT_LAT = 1;
  localparam int MAX_WAIT  = 100;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32), .ADDR_W(5)) bus ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request for one edge (edge k), then scramble the operands.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Returns n such that done was first seen in cycle k+n, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_k+1", 32'(bus.busy), 32'd1);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    issue(v.op, v.a, v.b, v.rd);
    wait_done(lat);
    check({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    if (lat < 0) return;
    check({name, "_data"}, bus.wb_data, v.exp_data);
    check({name, "_addr"}, 32'(bus.wb_addr), 32'(v.rd));
    check({name, "_we"},   32'(bus.wb_we), 32'(v.rd != 5'd0));
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({name, "_done_off"}, 32'(bus.done), 32'd0);
    check({name, "_we_off"},   32'(bus.wb_we), 32'd0);
    check({name, "_idle"},     32'(bus.busy), 32'd0);
    check({name, "_hold"},     bus.wb_data, v.exp_data);
  endtask

  initial begin
    int lat;
    int done_cnt;

    vecs[0]  = '{MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT};
    vecs[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{MDU_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 5'd9,  32'hFFFF_FFFA, DIV_LAT};
    vecs[5]  = '{MDU_REM,    32'hFFFF_FFEC, 32'h0000_0003, 5'd10, 32'hFFFF_FFFE, DIV_LAT};
    vecs[6]  = '{MDU_DIVU,   32'h0000_0014, 32'h0000_0003, 5'd11, 32'h0000_0006, DIV_LAT};
    vecs[7]  = '{MDU_DIVU,   32'h0000_002A, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF, SHORT_LAT};
    vecs[8]  = '{MDU_REM,    32'h0000_002A, 32'h0000_0000, 5'd13, 32'h0000_002A, SHORT_LAT};
    vecs[9]  = '{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, SHORT_LAT};
    vecs[10] = '{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, SHORT_LAT};
    vecs[11] = '{MDU_MUL,    32'h0000_0003, 32'h0000_0004, 5'd0,  32'h0000_000C, MUL_LAT};
    vecs[12] = '{MDU_REMU,   32'h0000_0064, 32'h0000_0007, 5'd16, 32'h0000_0002, DIV_LAT};
    vecs[13] = '{MDU_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 5'd17, 32'hFFFF_FFFF, DIV_LAT};
    vecs[14] = '{MDU_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD, DIV_LAT};
    vecs[15] = '{MDU_MUL,    32'h1234_5678, 32'h0000_0010, 5'd31, 32'h2345_6780, MUL_LAT};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = MDU_MUL;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_we",   32'(bus.wb_we), 32'd0);
    check("rst_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_data", bus.wb_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start pulsed again while busy must be dropped: exactly one done.
    issue(MDU_MUL, 32'd9, 32'd11, 5'd3);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.a     = 32'd50;
    bus.b     = 32'd0;
    bus.rd_in = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        check("busy_ign_data", bus.wb_data, 32'd99);
        check("busy_ign_addr", 32'(bus.wb_addr), 32'd3);
      end
    end
    check("busy_ign_count", 32'(done_cnt), 32'd1);

    // A start held through DONE is taken in the following IDLE cycle.
    issue(MDU_REMU, 32'd17, 32'd5, 5'd20);
    wait_done(lat);
    check("b2b_first", bus.wb_data, 32'd2);
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.a     = 32'd42;
    bus.b     = 32'd0;
    bus.rd_in = 5'd9;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done", 32'(bus.done), 32'd1);
    check("b2b_data", bus.wb_data, 32'hFFFF_FFFF);
    check("b2b_addr", 32'(bus.wb_addr), 32'd9);

    // Reset ten cycles into a divide aborts it without a write-back.
    @(negedge clk);
    issue(MDU_DIV, 32'hFFFF_FFEC, 32'd3, 5'd21);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_we",   32'(bus.wb_we), 32'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    run_vec("post_rst", vecs[6]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
